// File: rtl/m2m_control_fsm_if.sv
// Control-unit <-> datapath/memory signal bundle for the m2m processor.
// master: the control FSM (drives strobes, reads flags); slave: datapath + memory.
interface m2m_control_fsm_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       alu_zero;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       a_load;
    logic       b_load;
    logic       res_load;
    logic [2:0] alu_op;

    modport master (
        input  opcode, mem_ready, alu_zero,
        output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
               a_load, b_load, res_load, alu_op
    );

    modport slave (
        output opcode, mem_ready, alu_zero,
        input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
               a_load, b_load, res_load, alu_op
    );
endinterface

// File: rtl/m2m_control_fsm.sv
// Multi-cycle control unit for the 16-bit memory-to-memory datapath.
// Sequences fetch / operand loads / execute / store / branch over one shared
// memory port. Optional memory-wait watchdog: define MEM_TIMEOUT_EN.
module m2m_control_fsm #(
    parameter int unsigned STATE_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK,
    input  logic                   reset,
    m2m_control_fsm_if.master      bus,
    output logic [STATE_W-1:0]     state,
    output logic                   instr_done,
    output logic [15:0]            instr_count,
    output logic                   illegal,
    output logic                   halted,
    output logic                   fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_EXEC   = 3'd4,
        S_STORE  = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_PASS = 3'd4;

    state_t st;

    assign state = STATE_W'(st);

    // Datapath strobes and memory request, decoded from the current state and inputs.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 2'd0;
        bus.ir_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.a_load   = 1'b0;
        bus.b_load   = 1'b0;
        bus.res_load = 1'b0;
        bus.alu_op   = 3'd0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            case (st)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.ir_load = bus.mem_ready;
                    bus.pc_inc  = bus.mem_ready;
                end
                S_DECODE: begin
                    illegal    = bus.opcode[3];
                    instr_done = bus.opcode[3];
                end
                S_LOAD_A: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 2'd1;
                    bus.a_load   = bus.mem_ready;
                end
                S_LOAD_B: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 2'd2;
                    bus.b_load   = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.res_load = 1'b1;
                    bus.alu_op   = (bus.opcode == OP_MOV) ? ALU_PASS : 3'(bus.opcode[1:0]);
                end
                S_STORE: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.addr_sel = 2'd3;
                    instr_done   = bus.mem_ready;
                end
                S_BRANCH: begin
                    bus.alu_op  = ALU_SUB;
                    bus.pc_load = (bus.opcode == OP_JMP) ||
                                  ((bus.opcode == OP_BEQ) && bus.alu_zero);
                    instr_done  = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES + 1 > 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WAIT_W-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign fault          = 1'b0;
`endif

    // State sequencing, retired-instruction counter and optional memory watchdog.
    always_ff @(posedge CLK) begin
        if (reset) begin
            st          <= S_FETCH;
            instr_count <= 16'd0;
`ifdef MEM_TIMEOUT_EN
            fault       <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            if (instr_done && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'd1;
            end
            case (st)
                S_FETCH:  if (bus.mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    if (bus.opcode[3])                st <= S_FETCH;
                    else if (bus.opcode == OP_JMP)    st <= S_BRANCH;
                    else if (bus.opcode == OP_HALT)   st <= S_HALT;
                    else                              st <= S_LOAD_A;
                end
                S_LOAD_A: if (bus.mem_ready) st <= (bus.opcode == OP_MOV) ? S_EXEC : S_LOAD_B;
                S_LOAD_B: if (bus.mem_ready) st <= (bus.opcode == OP_BEQ) ? S_BRANCH : S_EXEC;
                S_EXEC:   st <= S_STORE;
                S_STORE:  if (bus.mem_ready) st <= S_FETCH;
                S_BRANCH: st <= S_FETCH;
                S_HALT:   st <= S_HALT;
                default:  st <= S_FETCH;
            endcase
`ifdef MEM_TIMEOUT_EN
            // Counter only runs while a request is stalled, so any other cycle
            // (including entry into a memory state) starts it from zero.
            if (bus.mem_req && !bus.mem_ready) begin
                if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    fault <= 1'b1;
                    st    <= S_HALT;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_m2m_control_fsm.sv
// Bench for m2m_control_fsm: an instruction-level model expands each
// instruction (opcode, memory wait counts, alu_zero) into the per-cycle
// inputs and expected outputs; one loop drives and checks every cycle.
module tb_m2m_control_fsm;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        CLK;
    logic        reset;
    logic [15:0] state;
    logic        instr_done;
    logic [15:0] instr_count;
    logic        illegal;
    logic        halted;
    logic        fault;

    m2m_control_fsm_if bus();

    m2m_control_fsm #(.STATE_W(16), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .bus         (bus),
        .state       (state),
        .instr_done  (instr_done),
        .instr_count (instr_count),
        .illegal     (illegal),
        .halted      (halted),
        .fault       (fault)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       az;
        logic [3:0] op;
        int         st;
        logic       req;
        logic       we;
        logic [1:0] asel;
        logic       ir;
        logic       pci;
        logic       pcl;
        logic       al;
        logic       bl;
        logic       rl;
        logic [2:0] aop;
        logic       done;
        logic       ill;
        logic       hlt;
        logic       flt;
        int         cnt;
        bit         skip;
        int         pin;
    } cyc_t;

    cyc_t q[$];
    int   m_cnt;
    logic m_flt;
    int   pend_pin;
    int   tests;
    int   fails;

    function automatic void chk(string name, int idx, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endfunction

    function automatic cyc_t mk(int st, logic [3:0] op);
        cyc_t c;
        c.rst = 1'b0; c.rdy = 1'b0; c.az = 1'b0; c.op = op;
        c.st = st; c.req = 1'b0; c.we = 1'b0; c.asel = 2'd0;
        c.ir = 1'b0; c.pci = 1'b0; c.pcl = 1'b0; c.al = 1'b0; c.bl = 1'b0;
        c.rl = 1'b0; c.aop = 3'd0; c.done = 1'b0; c.ill = 1'b0; c.hlt = 1'b0;
        c.flt = 1'b0; c.cnt = 0; c.skip = 1'b0; c.pin = -1;
        return c;
    endfunction

    // Appends a cycle; registered outputs reflect everything retired before it.
    function automatic void push(cyc_t c);
        c.cnt = m_cnt;
        c.flt = m_flt;
        c.pin = pend_pin;
        pend_pin = -1;
        q.push_back(c);
        if (c.done && m_cnt < 65535) m_cnt++;
    endfunction

    function automatic cyc_t mk_mem(int st, logic [3:0] op, logic [1:0] asel, logic we, logic rdy);
        cyc_t c;
        c = mk(st, op);
        c.req = 1'b1; c.asel = asel; c.we = we; c.rdy = rdy;
        return c;
    endfunction

    function automatic void mem_wait(int st, logic [3:0] op, logic [1:0] asel, logic we, int n);
        for (int i = 0; i < n; i++) push(mk_mem(st, op, asel, we, 1'b0));
    endfunction

    function automatic void reset_cycles(int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(0, 4'd0);
            c.rst = 1'b1; c.rdy = 1'b1; c.skip = (i == 0);
            push(c);
            m_cnt = 0;
            m_flt = 1'b0;
        end
    endfunction

    function automatic void halt_cycles(int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(7, 4'd7);
            c.hlt = 1'b1;
            push(c);
        end
    endfunction

    // One whole instruction; returns its length in cycles.
    function automatic int instr(logic [3:0] op, int wf, int wa, int wb, int ws, logic az);
        cyc_t c;
        int   start;
        start = q.size();
        mem_wait(0, op, 2'd0, 1'b0, wf);
        c = mk_mem(0, op, 2'd0, 1'b0, 1'b1); c.ir = 1'b1; c.pci = 1'b1; push(c);
        c = mk(1, op);
        if (op >= 4'd8) begin c.ill = 1'b1; c.done = 1'b1; end
        push(c);
        if (op <= 4'd5) begin
            mem_wait(2, op, 2'd1, 1'b0, wa);
            c = mk_mem(2, op, 2'd1, 1'b0, 1'b1); c.al = 1'b1; push(c);
            if (op != 4'd4) begin
                mem_wait(3, op, 2'd2, 1'b0, wb);
                c = mk_mem(3, op, 2'd2, 1'b0, 1'b1); c.bl = 1'b1; push(c);
            end
            if (op != 4'd5) begin
                c = mk(4, op); c.rl = 1'b1;
                c.aop = (op == 4'd4) ? 3'd4 : op[2:0];
                push(c);
                mem_wait(5, op, 2'd3, 1'b1, ws);
                c = mk_mem(5, op, 2'd3, 1'b1, 1'b1); c.done = 1'b1; push(c);
            end
        end
        if (op == 4'd5 || op == 4'd6) begin
            c = mk(6, op); c.az = az; c.aop = 3'd1;
            c.pcl = (op == 4'd6) || az; c.done = 1'b1;
            push(c);
        end
        return q.size() - start;
    endfunction

    initial begin
        int   lat;
        cyc_t c;
        reset = 1'b1;
        bus.opcode = 4'd0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
        tests = 0; fails = 0; m_cnt = 0; m_flt = 1'b0; pend_pin = -1;

        // ADD, no waits
        reset_cycles(2);
        lat = instr(4'd0, 0, 0, 0, 0, 1'b0); chk("lat_add", -1, lat, 6);
        pend_pin = 1;
        // MOV with 3-cycle LOAD_A wait
        lat = instr(4'd4, 0, 3, 0, 0, 1'b0); chk("lat_mov_wait3", -1, lat, 8);
        pend_pin = 2;
        // BEQ taken then not taken
        reset_cycles(2);
        lat = instr(4'd5, 0, 0, 0, 0, 1'b1); chk("lat_beq", -1, lat, 5);
        lat = instr(4'd5, 0, 0, 0, 0, 1'b0);
        pend_pin = 2;
        // JMP, illegal 9, HALT
        reset_cycles(2);
        lat = instr(4'd6, 0, 0, 0, 0, 1'b0); chk("lat_jmp", -1, lat, 3);
        lat = instr(4'd9, 0, 0, 0, 0, 1'b0); chk("lat_illegal", -1, lat, 2);
        lat = instr(4'd7, 0, 0, 0, 0, 1'b0);
        pend_pin = 2;
        halt_cycles(20);
        reset_cycles(2);
        pend_pin = 0;
        // ADD aborted by reset while LOAD_B is stalled
        c = mk_mem(0, 4'd0, 2'd0, 1'b0, 1'b1); c.ir = 1'b1; c.pci = 1'b1; push(c);
        push(mk(1, 4'd0));
        c = mk_mem(2, 4'd0, 2'd1, 1'b0, 1'b1); c.al = 1'b1; push(c);
        mem_wait(3, 4'd0, 2'd2, 1'b0, 2);
        reset_cycles(2);
        // Remaining ALU ops and a stalled BEQ, with waits at every memory phase
        lat = instr(4'd1, 2, 0, 1, 2, 1'b0);
        lat = instr(4'd2, 0, 1, 0, 0, 1'b0);
        lat = instr(4'd3, 1, 1, 1, 1, 1'b0);
        lat = instr(4'd5, 1, 2, 3, 0, 1'b1);
        lat = instr(4'd12, 1, 0, 0, 0, 1'b0);
        pend_pin = 5;
        // Memory never answers in FETCH
        reset_cycles(2);
`ifdef MEM_TIMEOUT_EN
        mem_wait(0, 4'd0, 2'd0, 1'b0, 4);
        m_flt = 1'b1;
        halt_cycles(5);
`else
        mem_wait(0, 4'd0, 2'd0, 1'b0, 1000);
`endif
        reset_cycles(2);

        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            reset         = q[i].rst;
            bus.mem_ready = q[i].rdy;
            bus.alu_zero  = q[i].az;
            bus.opcode    = q[i].op;
            #2;
            if (!q[i].skip) begin
                chk("state", i, int'(state), q[i].st);
                chk("instr_count", i, int'(instr_count), q[i].cnt);
                chk("fault", i, int'(fault), int'(q[i].flt));
            end
            chk("mem_req", i, int'(bus.mem_req), int'(q[i].req));
            chk("mem_we", i, int'(bus.mem_we), int'(q[i].we));
            chk("ir_load", i, int'(bus.ir_load), int'(q[i].ir));
            chk("pc_inc", i, int'(bus.pc_inc), int'(q[i].pci));
            chk("pc_load", i, int'(bus.pc_load), int'(q[i].pcl));
            chk("a_load", i, int'(bus.a_load), int'(q[i].al));
            chk("b_load", i, int'(bus.b_load), int'(q[i].bl));
            chk("res_load", i, int'(bus.res_load), int'(q[i].rl));
            chk("instr_done", i, int'(instr_done), int'(q[i].done));
            chk("illegal", i, int'(illegal), int'(q[i].ill));
            chk("halted", i, int'(halted), int'(q[i].hlt));
            if (q[i].req) chk("addr_sel", i, int'(bus.addr_sel), int'(q[i].asel));
            if (!q[i].rst && (q[i].st == 4 || q[i].st == 6))
                chk("alu_op", i, int'(bus.alu_op), int'(q[i].aop));
            if (q[i].pin >= 0) chk("pinned_count", i, int'(instr_count), q[i].pin);
        end

        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m2m_control_fsm.md
Name: m2m_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit memory-to-memory processor datapath.
- Sequences fetch, operand loads, execute, store and branch through a single shared memory port, and drives the datapath load/select strobes.
- Exports `state` so benches count instructions by observing state==0, and keeps an instruction counter.

Parameters:
- STATE_W, 16, width of exported state code (upper bits zero).
- TIMEOUT_CYCLES, 255, memory wait limit; used only with MEM_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  4  IR[15:12] from datapath, valid from DECODE onward.
- mem_ready  input  1  memory completes current request this cycle.
- alu_zero  input  1  datapath A-B==0 flag, valid in BRANCH.
- mem_req  output  1  memory access request, held until mem_ready.
- mem_we  output  1  write qualifier for mem_req.
- addr_sel  output  2  0=PC, 1=field A, 2=field B, 3=field D.
- ir_load  output  1  latch MemOut into IR.
- pc_inc  output  1  PC <= PC+1.
- pc_load  output  1  PC <= branch target (field D).
- a_load  output  1  latch MemOut into A reg.
- b_load  output  1  latch MemOut into B reg.
- res_load  output  1  latch ALU result.
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS-A.
- state  output  STATE_W  current state code.
- instr_done  output  1  one-cycle pulse per retired instruction.
- instr_count  output  16  retired instructions, saturates at 0xFFFF.
- illegal  output  1  one-cycle pulse on undefined opcode.
- halted  output  1  high while in HALT.
- fault  output  1  sticky memory-timeout flag (0 without feature).

Behaviour:
- Reset (CLK edge with reset=1): state=FETCH(0), instr_count=0, fault=0. While reset is high, all strobes, mem_req, instr_done, illegal and halted are forced 0. Reset mid-access abandons the request; no strobe fires.
- Strobes are combinational from the registered state and inputs. state, instr_count and fault are registered.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MOV, 5 BEQ, 6 JMP, 7 HALT, 8-15 illegal.
- FETCH(0): mem_req=1, addr_sel=0.
  - On mem_ready: ir_load=1, pc_inc=1, go to DECODE. Otherwise stay.
- DECODE(1): one cycle, no memory access.
  - 0-5 go to LOAD_A.
  - 6 goes to BRANCH.
  - 7 goes to HALT.
  - 8-15: illegal=1, instr_done=1, go to FETCH.
- LOAD_A(2): mem_req=1, addr_sel=1.
  - On mem_ready: a_load=1.
  - MOV goes to EXEC; others go to LOAD_B.
- LOAD_B(3): mem_req=1, addr_sel=2.
  - On mem_ready: b_load=1.
  - BEQ goes to BRANCH; others go to EXEC.
- EXEC(4): res_load=1, alu_op from opcode (MOV uses PASS-A), go to STORE.
- STORE(5): mem_req=1, mem_we=1, addr_sel=3.
  - On mem_ready: instr_done=1, go to FETCH.
- BRANCH(6): alu_op=SUB.
  - pc_load=1 if opcode==JMP, or opcode==BEQ and alu_zero==1.
  - instr_done=1, go to FETCH.
- HALT(7): halted=1, no requests, stays until reset. HALT itself does not pulse instr_done.
- instr_count increments on each instr_done cycle and holds at 0xFFFF.
- Codes 8..2^STATE_W-1 are unreachable. Any other code goes to FETCH on the next edge.
- Minimum latency with mem_ready always 1:
  - ALU op: 6 cycles (FETCH, DECODE, LOAD_A, LOAD_B, EXEC, STORE).
  - MOV: 5 cycles.
  - BEQ: 5 cycles.
  - JMP: 3 cycles.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined: an 8+ bit wait counter clears on entry to any memory state and counts cycles with mem_req=1 and mem_ready=0. On reaching TIMEOUT_CYCLES, fault is set, the FSM goes to HALT and the request drops.
- When undefined: the FSM waits indefinitely, fault is tied 0, and no counter logic is present.

Test Plan:
- Reset held 2 cycles, mem_ready=1, opcode=0 (ADD) -> state sequence 0,1,2,3,4,5,0; instr_done pulses once on cycle 6; instr_count=1; alu_op=0 in EXEC; mem_we=1 only in STORE.
- MOV (opcode=4) with mem_ready delayed 3 cycles in LOAD_A -> mem_req and addr_sel=1 held steady 3 cycles; a_load only on the ready cycle; LOAD_B skipped; alu_op=4 in EXEC.
- BEQ with alu_zero=1, then BEQ with alu_zero=0 -> pc_load=1 in the first BRANCH, 0 in the second; no STORE entered; instr_count=2.
- JMP, then opcode=9, then HALT -> JMP: pc_load=1 after 3 cycles. Opcode 9: illegal pulse, instr_count=2. HALT: state=7 persists 20 cycles with halted=1, mem_req=0; reset returns state to 0 and instr_count to 0.
- Reset asserted in LOAD_B while waiting -> no b_load; state=0 next cycle; strobes 0 during reset.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> fault=1 and state=7 after 4 wait cycles; without the macro, state stays 0 for 1000 cycles.
